renee_nav_ctrl: RTL

//  Clocked, parametrised successor to the combinational beacon/bumper steering logic. Steers two wheels toward the

---
 rtl/nav_pkg.sv | 28 ++
 rtl/bumper_debounce.sv | 37 +++
 rtl/renee_nav_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/nav_pkg.sv
// Shared types for the beacon/bumper navigation controller.
// Wheel action encoding, controller states and the latched hit record.
package nav_pkg;

  localparam logic [2:0] WA_F = 3'b100;
  localparam logic [2:0] WA_R = 3'b010;
  localparam logic [2:0] WA_S = 3'b001;

  typedef enum logic [1:0] {
    TRACK,
    ESCAPE,
    TURN,
    FAULT
  } nav_state_e;

  typedef struct packed {
    logic lb;
    logic rb;
    logic fb;
    logic bb;
  } hit_t;

  // {lwa, rwa} for a pivot; right pivot drives the left wheel forward
  function automatic logic [5:0] pivot(input logic right);
    return right ? {WA_F, WA_R} : {WA_R, WA_F};
  endfunction

endpackage

// File: rtl/bumper_debounce.sv
// Per-bumper debouncer: saturating high-count, cleared on any low sample.
// deb asserts once the raw input has been high for DEBOUNCE edges.
module bumper_debounce #(
  parameter int DEBOUNCE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!raw) begin
      cnt_d = '0;
    end else if (cnt_q != DB_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign deb = (cnt_q == DB_MAX);

endmodule

// File: rtl/renee_nav_ctrl.sv
// Beacon-tracking wheel controller with bumper escape manoeuvre.
// Wheel actions are registered from the next state and current inputs.
module renee_nav_ctrl
  import nav_pkg::*;
#(
  parameter int SENS_W      = 3,
  parameter int DEBOUNCE    = 2,
  parameter int BACK_CYCLES = 8,
  parameter int TURN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SENS_W-1:0] ls,
  input  logic [SENS_W-1:0] rs,
  input  logic              lb,
  input  logic              rb,
  input  logic              fb,
  input  logic              bb,
  output logic [2:0]        lwa,
  output logic [2:0]        rwa,
  output logic              fault,
  output logic              busy
);

  localparam int MAXC =
    (BACK_CYCLES > TURN_CYCLES) ? BACK_CYCLES : TURN_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] BACK_LD = CW'(BACK_CYCLES - 1);
  localparam logic [CW-1:0] TURN_LD = CW'(TURN_CYCLES - 1);

  logic lb_d, rb_d, fb_d, bb_d;

  bumper_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_l (
    .clk(clk), .rst_n(rst_n), .raw(lb), .deb(lb_d)
  );
  bumper_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_r (
    .clk(clk), .rst_n(rst_n), .raw(rb), .deb(rb_d)
  );
  bumper_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_f (
    .clk(clk), .rst_n(rst_n), .raw(fb), .deb(fb_d)
  );
  bumper_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_b (
    .clk(clk), .rst_n(rst_n), .raw(bb), .deb(bb_d)
  );

  nav_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  hit_t          hit_q, hit_d;
  logic [2:0]    lwa_q, lwa_d;
  logic [2:0]    rwa_q, rwa_d;
  logic          fault_q, fault_d;
  logic          busy_q, busy_d;

  hit_t deb;
  logic any_hit;
  logic all_hit;
  logic l_weak;
  logic r_weak;
  logic no_sig;

  assign deb     = '{lb: lb_d, rb: rb_d, fb: fb_d, bb: bb_d};
  assign any_hit = |deb;
  assign all_hit = &deb;
  assign l_weak  = (ls > rs);
  assign r_weak  = (ls < rs);
  assign no_sig  = &ls;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    unique case (state_q)
      TRACK: begin
        if (any_hit) begin
          hit_d   = deb;
          cnt_d   = BACK_LD;
          state_d = ESCAPE;
        end
      end
      ESCAPE: begin
        if (cnt_q == '0) begin
          cnt_d   = TURN_LD;
          state_d = TURN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      TURN: begin
        if (any_hit) begin
          hit_d   = deb;
          cnt_d   = BACK_LD;
          state_d = ESCAPE;
        end else if (cnt_q == '0) begin
          state_d = TRACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
    endcase
    if (all_hit) begin
      state_d = FAULT;
    end
  end

  always_comb begin
    lwa_d = WA_S;
    rwa_d = WA_S;
    unique case (state_d)
      TRACK: begin
        unique case (1'b1)
          l_weak: begin lwa_d = WA_F; rwa_d = WA_S; end
          r_weak: begin lwa_d = WA_S; rwa_d = WA_F; end
          no_sig: begin lwa_d = WA_S; rwa_d = WA_S; end
          default: begin lwa_d = WA_F; rwa_d = WA_F; end
        endcase
      end
      ESCAPE: begin
        if (hit_d.bb && !hit_d.fb) begin
          lwa_d = WA_F;
          rwa_d = WA_F;
        end else begin
          lwa_d = WA_R;
          rwa_d = WA_R;
        end
      end
      TURN: begin
        if (hit_d.lb && !hit_d.rb) begin
          {lwa_d, rwa_d} = pivot(1'b1);
        end else if (hit_d.rb && !hit_d.lb) begin
          {lwa_d, rwa_d} = pivot(1'b0);
        end else begin
          {lwa_d, rwa_d} = pivot(!r_weak);
        end
      end
      FAULT: begin
        lwa_d = WA_S;
        rwa_d = WA_S;
      end
    endcase
    fault_d = (state_d == FAULT);
    busy_d  = (state_d == ESCAPE) || (state_d == TURN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= TRACK;
      cnt_q   <= '0;
      hit_q   <= '0;
      lwa_q   <= WA_S;
      rwa_q   <= WA_S;
      fault_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      lwa_q   <= lwa_d;
      rwa_q   <= rwa_d;
      fault_q <= fault_d;
      busy_q  <= busy_d;
    end
  end

  assign lwa   = lwa_q;
  assign rwa   = rwa_q;
  assign fault = fault_q;
  assign busy  = busy_q;

endmodule
